// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with start/busy/done handshake
// Ports: clk, rst (sync active-high); Start_E/Flush_E request and abort;
//        MulDivOp_E funct3 selects the operation; SrcA_E/SrcB_E operands;
//        Busy_E stalls the pipeline, Done_E pulses with MulDivResult_E valid.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Start_E,
    input  logic            Flush_E,
    input  logic [2:0]      MulDivOp_E,
    input  logic [XLEN-1:0] SrcA_E,
    input  logic [XLEN-1:0] SrcB_E,
    output logic            Busy_E,
    output logic            Done_E,
    output logic [XLEN-1:0] MulDivResult_E
);
    localparam int CW = $clog2(ITER);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;
    state_t state, state_n;
    logic [2:0] op;
    logic sa, sb;
    logic [XLEN-1:0] hi, lo, mag_b;
    logic [CW-1:0] cnt;
    logic accept, fast, sa_in, sb_in, nb;
    logic [XLEN-1:0] mag_a_in, mag_b_in, fast_res, hi_it, lo_it, quo, rem, fin_res;
    logic [XLEN:0] mul_sum;
    logic [XLEN+1:0] div_diff;
    logic [2*XLEN-1:0] prod;
    // Unsigned operands: SrcA for MULHU/DIVU/REMU, SrcB additionally for MULHSU.
    always_comb begin
        sa_in = SrcA_E[XLEN-1] & ~(MulDivOp_E[0] & (MulDivOp_E[1] | MulDivOp_E[2]));
        sb_in = SrcB_E[XLEN-1] & (MulDivOp_E[2] ? ~MulDivOp_E[0] : ~MulDivOp_E[1]);
        mag_a_in = sa_in ? -SrcA_E : SrcA_E;
        mag_b_in = sb_in ? -SrcB_E : SrcB_E;
        accept = (state == IDLE) & Start_E & ~Flush_E;
        fast = MulDivOp_E[2] & ((SrcB_E == '0) |
               (~MulDivOp_E[0] & (SrcA_E == MIN) & (SrcB_E == '1)));
        fast_res = (SrcB_E == '0) ? (MulDivOp_E[1] ? SrcA_E : '1) : (MulDivOp_E[1] ? '0 : MIN);
    end
    // Shared datapath: hi holds product high / partial remainder, lo holds
    // multiplier / dividend shifting out while quotient bits shift in.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
        div_diff = {1'b0, hi, lo[XLEN-1]} - {2'b0, mag_b};
        // A non-borrowing result is always below the divisor, so bit XLEN is
        // zero then; folding it in keeps the test exact and uses every bit.
        nb = ~|div_diff[XLEN+1:XLEN];
        hi_it = op[2] ? (nb ? div_diff[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]}) : mul_sum[XLEN:1];
        lo_it = op[2] ? {lo[XLEN-2:0], nb} : {mul_sum[0], lo[XLEN-1:1]};
        prod = (sa ^ sb) ? -{hi, lo} : {hi, lo};
        quo = (sa ^ sb) ? -lo : lo;
        rem = sa ? -hi : hi;
        fin_res = op[2] ? (op[1] ? rem : quo) :
                  (op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (fast ? DONE : RUN) : IDLE;
            RUN:     state_n = Flush_E ? IDLE : (cnt == CW'(ITER-1) ? FINISH : RUN);
            FINISH:  state_n = Flush_E ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            Busy_E <= 1'b0;
            Done_E <= 1'b0;
            MulDivResult_E <= '0;
            cnt <= '0;
            op <= '0;
            sa <= 1'b0;
            sb <= 1'b0;
            hi <= '0;
            lo <= '0;
            mag_b <= '0;
        end else begin
            state <= state_n;
            Busy_E <= (state_n == RUN) | (state_n == FINISH);
            Done_E <= state_n == DONE;
            if (accept) begin
                op <= MulDivOp_E;
                sa <= sa_in;
                sb <= sb_in;
                hi <= '0;
                lo <= mag_a_in;
                mag_b <= mag_b_in;
                cnt <= '0;
                if (fast) MulDivResult_E <= fast_res;
            end else if (state == RUN) begin
                hi <= hi_it;
                lo <= lo_it;
                cnt <= cnt + 1'b1;
            end
            if (state == FINISH && !Flush_E) MulDivResult_E <= fin_res;
        end
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, sitting beside the single-cycle ALU.
- Takes the same SrcA_E/SrcB_E operands and produces a 32-bit result after a multi-cycle run.
- Provides a start/busy/done handshake so hazard logic can stall the pipeline until the result is ready.
- One radix-2 iteration per cycle, using a shared shift-add/restoring-subtract datapath.

Parameters:
- XLEN, 32, operand and result width.
- ITER, 32, iterations per run; must equal XLEN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- Start_E  input  1  request; accepted only in IDLE.
- Flush_E  input  1  abort the operation in flight (branch mispredict/flush).
- MulDivOp_E  input  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA_E  input  32  rs1 operand (multiplicand/dividend).
- SrcB_E  input  32  rs2 operand (multiplier/divisor).
- Busy_E  output  1  high from the cycle after accept until Done_E; drives the stall.
- Done_E  output  1  one-cycle pulse; MulDivResult_E is valid in that cycle.
- MulDivResult_E  output  32  result; registered and held until the next accept.

Behaviour:
- Interface rules:
  - One clock, clk.
  - Reset is synchronous and active-high on rst.
  - All outputs are registered.
- Reset values: Busy_E=0, Done_E=0, MulDivResult_E=0, state=IDLE, iteration count=0.
- States: IDLE, RUN, FINISH, DONE.
- IDLE:
  - On an edge with Start_E=1, latch op, SrcA_E and SrcB_E.
  - Record operand signs and hold magnitudes: signed ops use |x|; MULHSU treats only SrcA as signed.
  - Go to RUN, count=0.
  - Later changes on the input ports are ignored until the next accept.
- Fast path (decided at the accept edge, skips RUN):
  - DIV/DIVU/REM/REMU with SrcB=0: go directly to DONE. Quotient=0xFFFFFFFF; remainder=SrcA unchanged.
  - DIV/REM with SrcA=0x80000000 and SrcB=0xFFFFFFFF: go directly to DONE. Quotient=0x80000000; remainder=0.
  - Done_E is visible the cycle after the accept edge.
- RUN: one iteration per edge; count increments; leave for FINISH when count reaches ITER-1.
  - Multiply: 64-bit accumulator, shift-add on unsigned magnitudes, LSB-first.
  - Divide: restoring, MSB-first. 32-bit remainder register, subtract done at 33-bit width; quotient bit = no borrow.
- FINISH (one edge):
  - Apply sign correction by two's complement.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - Select low word (MUL), high word (MULH/MULHSU/MULHU), quotient or remainder; register into MulDivResult_E; go to DONE.
- DONE: Done_E=1 and Busy_E=0 for exactly one cycle, then IDLE.
- Latency, normal path:
  - Accept at edge 0.
  - Iterations at edges 1..32.
  - FINISH at edge 33.
  - Done_E high in the cycle after edge 33.
- Busy_E: high in RUN and FINISH only.
- Start_E handling:
  - Ignored in RUN, FINISH and DONE.
  - Start_E during DONE is not queued; it must be re-presented in IDLE.
  - Back-to-back throughput is one op per 35 cycles.
- Flush_E:
  - In RUN/FINISH: next edge goes to IDLE with Busy_E=0, no Done_E, MulDivResult_E keeps its previous value.
  - In DONE: no effect; the pulse completes.
  - In IDLE, Flush_E=1 with Start_E=1: flush wins; nothing is accepted.
- rst asserted mid-operation: next edge restores all reset values regardless of state; rst has priority over Flush_E and Start_E.
- Arithmetic: no X propagation; every path is fully assigned, default result 0.

Test Plan:
- MUL: SrcA=7, SrcB=0xFFFFFFFD, Start pulse → Busy_E high for 33 cycles, Done_E pulse 34 cycles after accept, MulDivResult_E=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 100/0 → Done_E the cycle after accept with 0xFFFFFFFF; REMU 100/0 → 100.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0. Both on the fast path.
- Start DIV, assert Flush_E at iteration 10 → Busy_E=0 next cycle, no Done_E, result unchanged. A fresh MUL 3×5 then returns 15.
- Start while Busy_E=1 is ignored and the original result is correct. rst at iteration 20 → all outputs 0 next cycle. Start with Flush_E high in IDLE → no accept.
